// File: rtl/hb_ca_serializer.sv
// hb_ca_serializer: shifts the 48-bit HyperBus command-address word onto DQ
// one byte per clock with CS# low, picks 1x/2x initial latency from RWDS,
// counts that latency, hands the bus to the data stage and then holds CS#
// high for a recovery gap before the next command.
//
// Handshake: a CA word transfers on a rising clk edge where ca_valid and
// ca_ready are both high; ca_ready is high only in IDLE, ca_valid seen in any
// other state is ignored and the word stays with the producer.
module hb_ca_serializer #(
  parameter int LATENCY = 6,
  parameter int RECOV   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ca_valid,
  output logic        ca_ready,
  input  logic [47:0] ca_word,
  input  logic        xfer_end,
  output logic        hb_cs_n,
  output logic        hb_ck_en,
  output logic [7:0]  hb_dq_out,
  output logic        hb_dq_oe,
  input  logic        hb_rwds_in,
  output logic        lat_done,
  output logic        is_read,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CA    = 3'd1,
    S_LAT   = 3'd2,
    S_DATA  = 3'd3,
    S_RECOV = 3'd4
  } state_t;

  // Recovery counter holds RECOV-1 down to 0.
  localparam int RW = (RECOV > 2) ? $clog2(RECOV) : 1;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [47:0]   r_ca;
  logic [2:0]    r_idx;
  logic [4:0]    r_lat_cnt;
  logic [RW-1:0] r_rec_cnt;

  logic          w_zero_lat;
  logic [4:0]    w_lat_load;
  logic [2:0]    w_idx_nxt;
  logic [47:0]   w_src;
  logic [7:0]    w_byte;
  logic          w_cs_n_nxt;
  logic          w_ck_en_nxt;
  logic          w_dq_oe_nxt;
  logic [7:0]    w_dq_out_nxt;
  logic          w_lat_done_nxt;

  // A register-space write has no initial latency at all.
  assign w_zero_lat = ~r_ca[47] & r_ca[46];
  // RWDS high during CA means the device wants double latency.
  assign w_lat_load = hb_rwds_in ? 5'(4 * LATENCY) : 5'(2 * LATENCY);

  assign ca_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (ca_valid) w_state_nxt = S_CA;
      S_CA:    if (r_idx == 3'd5) w_state_nxt = w_zero_lat ? S_DATA : S_LAT;
      S_LAT:   if (r_lat_cnt == 5'd1) w_state_nxt = S_DATA;
      S_DATA:  if (xfer_end) w_state_nxt = S_RECOV;
      S_RECOV: if (r_rec_cnt == '0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pick the CA byte that will be on DQ next cycle; on accept it comes
  // straight from the input word, afterwards from the captured copy.
  always_comb begin
    w_idx_nxt = (r_state == S_IDLE) ? 3'd0 : (r_idx + 3'd1);
    w_src     = (r_state == S_IDLE) ? ca_word : r_ca;
    case (w_idx_nxt)
      3'd0:    w_byte = w_src[47:40];
      3'd1:    w_byte = w_src[39:32];
      3'd2:    w_byte = w_src[31:24];
      3'd3:    w_byte = w_src[23:16];
      3'd4:    w_byte = w_src[15:8];
      3'd5:    w_byte = w_src[7:0];
      default: w_byte = 8'h00;
    endcase
  end

  // Bus pin values for the state being entered, so the pins are registered.
  always_comb begin
    w_cs_n_nxt     = 1'b1;
    w_ck_en_nxt    = 1'b0;
    w_dq_oe_nxt    = 1'b0;
    w_dq_out_nxt   = 8'h00;
    w_lat_done_nxt = 1'b0;
    case (w_state_nxt)
      S_CA: begin
        w_cs_n_nxt   = 1'b0;
        w_ck_en_nxt  = 1'b1;
        w_dq_oe_nxt  = 1'b1;
        w_dq_out_nxt = w_byte;
      end
      S_LAT: begin
        w_cs_n_nxt  = 1'b0;
        w_ck_en_nxt = 1'b1;
      end
      S_DATA: begin
        w_cs_n_nxt     = 1'b0;
        w_ck_en_nxt    = 1'b1;
        w_lat_done_nxt = (r_state != S_DATA);
      end
      default: ;
    endcase
  end

  // State, datapath counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ca      <= '0;
      r_idx     <= 3'd0;
      r_lat_cnt <= 5'd0;
      r_rec_cnt <= '0;
      hb_cs_n   <= 1'b1;
      hb_ck_en  <= 1'b0;
      hb_dq_oe  <= 1'b0;
      hb_dq_out <= 8'h00;
      lat_done  <= 1'b0;
      is_read   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      hb_cs_n   <= w_cs_n_nxt;
      hb_ck_en  <= w_ck_en_nxt;
      hb_dq_oe  <= w_dq_oe_nxt;
      hb_dq_out <= w_dq_out_nxt;
      lat_done  <= w_lat_done_nxt;
      case (r_state)
        S_IDLE: begin
          if (ca_valid) begin
            r_ca    <= ca_word;
            is_read <= ca_word[47];
            r_idx   <= 3'd0;
          end
        end
        S_CA: begin
          if (r_idx == 3'd5) begin
            r_lat_cnt <= w_lat_load;
          end else begin
            r_idx <= r_idx + 3'd1;
          end
        end
        S_LAT: begin
          r_lat_cnt <= r_lat_cnt - 5'd1;
        end
        S_DATA: begin
          if (xfer_end) r_rec_cnt <= RW'(RECOV - 1);
        end
        S_RECOV: begin
          if (r_rec_cnt != '0) begin
            r_rec_cnt <= r_rec_cnt - 1'b1;
          end else begin
            is_read <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hb_ca_serializer.sv
// Directed bench for hb_ca_serializer with LATENCY=6, RECOV=2.
module tb_hb_ca_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        ca_valid;
  logic        ca_ready;
  logic [47:0] ca_word;
  logic        xfer_end;
  logic        hb_cs_n;
  logic        hb_ck_en;
  logic [7:0]  hb_dq_out;
  logic        hb_dq_oe;
  logic        hb_rwds_in;
  logic        lat_done;
  logic        is_read;
  logic        busy;
  logic [2:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  int         exp_lat_q[$];

  hb_ca_serializer #(.LATENCY(6), .RECOV(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .ca_valid   (ca_valid),
    .ca_ready   (ca_ready),
    .ca_word    (ca_word),
    .xfer_end   (xfer_end),
    .hb_cs_n    (hb_cs_n),
    .hb_ck_en   (hb_ck_en),
    .hb_dq_out  (hb_dq_out),
    .hb_dq_oe   (hb_dq_oe),
    .hb_rwds_in (hb_rwds_in),
    .lat_done   (lat_done),
    .is_read    (is_read),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Advance one cycle; sample point is 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Offer a CA word, check the six DQ bytes against the scoreboard and
  // measure cycles from the first post-CA cycle (T+7) to lat_done.
  // Returns in the lat_done cycle. RWDS carries the wrong value except in the
  // byte-5 cycle. With pulse_end, xfer_end is pulsed during CA and LAT.
  task automatic run_ca(input logic [47:0] w, input logic rwds,
                        input int exp_lat, input logic pulse_end);
    int n;
    int lat_exp;
    logic [7:0] b;
    ca_word  = w;
    ca_valid = 1'b1;
    for (int i = 0; i < 6; i++) exp_q.push_back(w[47-8*i -: 8]);
    exp_lat_q.push_back(exp_lat);
    n = 0;
    while (!ca_ready && n < 20) begin
      step();
      n++;
    end
    check("ca_ready_before_accept", ca_ready, 1'b1);
    step();  // accept edge T
    ca_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      check("ca_dq_byte", hb_dq_out, b);
      check("ca_dq_oe", hb_dq_oe, 1'b1);
      check("ca_cs_n", hb_cs_n, 1'b0);
      hb_rwds_in = (i == 5) ? rwds : ~rwds;
      xfer_end   = pulse_end && (i == 2);
      step();
      xfer_end   = 1'b0;
    end
    if (exp_lat > 0) begin
      check("lat_cs_n", hb_cs_n, 1'b0);
      check("lat_dq_oe", hb_dq_oe, 1'b0);
      check("lat_ck_en", hb_ck_en, 1'b1);
    end
    n = 0;
    while (!lat_done && n < 40) begin
      xfer_end = pulse_end && (n == 3);
      step();
      xfer_end = 1'b0;
      n++;
    end
    lat_exp = (exp_lat_q.size() > 0) ? exp_lat_q.pop_front() : -1;
    check("lat_done_delay", 48'(n), 48'(lat_exp));
    check("is_read", is_read, w[47]);
    check("data_cs_n", hb_cs_n, 1'b0);
  endtask

  // Stay in DATA for n cycles, CS# low and no repeat of lat_done.
  task automatic data_hold(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check("data_hold_cs_n", hb_cs_n, 1'b0);
      check("data_hold_lat_done", lat_done, 1'b0);
    end
  endtask

  // End the transaction at edge E and walk the recovery gap to IDLE.
  task automatic end_xfer();
    xfer_end = 1'b1;
    step();  // edge E
    xfer_end = 1'b0;
    check("recov1_cs_n", hb_cs_n, 1'b1);
    check("recov1_ck_en", hb_ck_en, 1'b0);
    check("recov1_ca_ready", ca_ready, 1'b0);
    step();
    check("recov2_cs_n", hb_cs_n, 1'b1);
    check("recov2_busy", busy, 1'b1);
    step();
    check("idle_ca_ready", ca_ready, 1'b1);
    check("idle_busy", busy, 1'b0);
    check("idle_is_read", is_read, 1'b0);
  endtask

  initial begin
    rst        = 1'b1;
    ca_valid   = 1'b0;
    ca_word    = '0;
    xfer_end   = 1'b0;
    hb_rwds_in = 1'b0;
    step();
    step();
    check("rst_cs_n", hb_cs_n, 1'b1);
    check("rst_ck_en", hb_ck_en, 1'b0);
    check("rst_dq_oe", hb_dq_oe, 1'b0);
    check("rst_dq_out", hb_dq_out, 8'h00);
    check("rst_lat_done", lat_done, 1'b0);
    check("rst_is_read", is_read, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ca_ready", ca_ready, 1'b1);
    rst = 1'b0;
    step();

    // Read, single latency: lat_done at T+19.
    run_ca(48'h8000_0012_3456, 1'b0, 12, 1'b0);
    data_hold(2);
    end_xfer();

    // Same read, double latency, with stray xfer_end during CA and LAT.
    run_ca(48'h8000_0012_3456, 1'b1, 24, 1'b1);
    data_hold(3);
    end_xfer();

    // Register write: no LAT, zero-length data phase, next word held valid.
    run_ca(48'h6000_0000_0001, 1'b0, 0, 1'b0);
    ca_word  = 48'hA5C3_1234_5678;
    ca_valid = 1'b1;
    end_xfer();
    run_ca(48'hA5C3_1234_5678, 1'b0, 12, 1'b0);
    end_xfer();

    // Reset in the middle of LAT.
    ca_word    = 48'h9F00_0000_0040;
    ca_valid   = 1'b1;
    hb_rwds_in = 1'b0;
    step();
    ca_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("abort_pre_cs_n", hb_cs_n, 1'b0);
    check("abort_pre_busy", busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_cs_n", hb_cs_n, 1'b1);
    check("abort_ck_en", hb_ck_en, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_ca_ready", ca_ready, 1'b1);
    check("abort_is_read", is_read, 1'b0);

    // Register read after the abort.
    run_ca(48'hC000_0000_0100, 1'b0, 12, 1'b0);
    end_xfer();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hb_ca_serializer.md
# hb_ca_serializer

Downstream of the address decoder: accepts the 48-bit HyperBus command-address (CA) word, drives it onto the 8-bit DQ bus one byte per clock with CS# asserted, and samples RWDS to pick single or double initial latency. It counts that latency, hands the bus to the data stage, and holds CS# low until the data stage ends the transaction. It then enforces a CS# recovery gap before accepting the next CA word.

## Interface
- `LATENCY`, default 6: initial latency in bus-clock periods (1 period = 2 `clk` cycles); legal 3..7.
- `RECOV`, default 2: `clk` cycles CS# stays high between transactions; legal ≥1.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `ca_valid`  in  1  CA word offered.
- `ca_ready`  out  1  block can accept a CA word.
- `ca_word`  in  48  CA word; bit 47 = read, bit 46 = register space.
- `xfer_end`  in  1  one-cycle pulse from the data stage; the transaction is complete.
- `hb_cs_n`  out  1  HyperBus chip select, active-low.
- `hb_ck_en`  out  1  enables the external bus-clock generator.
- `hb_dq_out`  out  8  DQ drive value.
- `hb_dq_oe`  out  1  DQ output enable.
- `hb_rwds_in`  in  1  RWDS from device, already synchronized.
- `lat_done`  out  1  one-cycle pulse; the data phase starts this cycle.
- `is_read`  out  1  captured `ca_word[47]`; valid from accept until return to IDLE.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, CA, LAT, DATA, RECOV.
- IDLE:
  - `ca_ready`=1.
  - On `ca_valid & ca_ready`, register `ca_word` and `is_read`, clear the byte index, and go to CA.
- CA (6 cycles):
  - `hb_cs_n`=0, `hb_dq_oe`=1, `hb_ck_en`=1.
  - `hb_dq_out` sends bytes MSB first: `ca[47:40]`, `[39:32]`, `[31:24]`, `[23:16]`, `[15:8]`, `[7:0]`.
  - On the edge ending byte index 5, sample `hb_rwds_in`.
  - Load the latency counter with 4·LATENCY if RWDS=1, else 2·LATENCY.
  - Zero-latency case: write to register space (`ca[47]`=0, `ca[46]`=1) skips LAT and goes directly to DATA.
- LAT:
  - `hb_cs_n`=0, `hb_ck_en`=1, `hb_dq_oe`=0, `hb_dq_out`=0.
  - The counter decrements once per cycle.
  - Go to DATA on the cycle after the counter reaches 1, so LAT lasts exactly the loaded count.
- DATA:
  - `hb_cs_n`=0, `hb_ck_en`=1, `hb_dq_oe`=0.
  - `lat_done`=1 on the first DATA cycle only.
  - Stay until `xfer_end`=1, then go to RECOV.
- RECOV:
  - `hb_cs_n`=1, `hb_ck_en`=0, `hb_dq_oe`=0.
  - Lasts RECOV cycles, then goes to IDLE.
- `xfer_end` in IDLE, CA, LAT or RECOV is ignored. `ca_valid` outside IDLE is ignored; the word is not consumed.
- Counter width is 5 bits (max 28). Byte index is 3 bits and must not wrap past 5.

## Timing
- All outputs are registered except `ca_ready` and `busy`, which decode the state register.
- Reset values:
  - State = IDLE.
  - `hb_cs_n`=1; `hb_ck_en`, `hb_dq_oe`, `lat_done`, `is_read`=0; `hb_dq_out`=0x00.
  - Combinational outputs in IDLE: `busy`=0, `ca_ready`=1.
- Handshake to bus:
  - Accept at edge T.
  - `hb_cs_n` falls and byte 0 appears in cycle T+1.
  - Byte 5 is driven in T+6.
- Latency:
  - The first LAT cycle is T+7.
  - `lat_done` pulses at T+7+L, where L = 2·LATENCY or 4·LATENCY.
  - Zero-latency register write: `lat_done` pulses at T+7.
- End of transaction:
  - `xfer_end` at edge E makes `hb_cs_n`=1 in cycle E+1.
  - IDLE (`ca_ready`=1) is reached at E+1+RECOV.
- Back-to-back: minimum CS#-high time is RECOV cycles. A `ca_valid` held high is accepted on the first IDLE cycle.
- Simultaneous `xfer_end` and `lat_done` cycle: the transaction ends (zero-length data phase is legal).
- `rst` mid-transaction: at the next edge all outputs take reset values and the state returns to IDLE. CS# deasserts with no recovery gap, and the in-flight CA word is discarded.

## Test plan
- Reset, then read with CA=0x8000_0012_3456, RWDS=0, LATENCY=6:
  - Required: DQ bytes 0x80,0x00,0x00,0x12,0x34,0x56 in T+1..T+6, `hb_dq_oe`=1 throughout.
  - Required: `lat_done` at T+19, `is_read`=1.
- Same read with RWDS=1 → `lat_done` at T+31.
- Register write with CA=0x6000_0000_0001 → no LAT state, `lat_done` at T+7, `is_read`=0.
- `xfer_end` at E, RECOV=2, `ca_valid` held high → `hb_cs_n` high in E+1..E+2, next CA accepted at E+3, byte 0 at E+4.
- `rst` asserted during LAT → next cycle `hb_cs_n`=1, `hb_ck_en`=0, `busy`=0, `ca_ready`=1.
- `xfer_end` pulsed during CA and LAT → ignored; DATA is still entered and CS# stays low until a later `xfer_end`.
